// File: rtl/sr_sub_nb_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The ovf signal exists only when SR_SUB_OVF_EN is defined.
interface sr_sub_nb_if #(parameter int W = 8);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bo;
`ifdef SR_SUB_OVF_EN
  logic         ovf;
`endif

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, d, bo
`ifdef SR_SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, d, bo
`ifdef SR_SUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/sr_sub_nb.sv
// Bit-serial W-bit subtractor d = a - b, LSB first, one bit per clock.
// Define SR_SUB_OVF_EN to add the signed-overflow output ovf.
module sr_sub_nb #(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  sr_sub_nb_if.slave  bus
);
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   sa_q, sa_d, sb_q, sb_d, d_q, d_d;
  logic           br_q, br_d, bo_q, bo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           in_rdy, out_vld, acc, last;
  logic           x, y, dbit, br_n;
`ifdef SR_SUB_OVF_EN
  logic           amsb_q, amsb_d, bmsb_q, bmsb_d, ovf_q, ovf_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign acc  = bus.in_valid & in_rdy;
  assign last = (cnt_q == CW'(W - 1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (acc)           state_d = S_RUN;
      S_RUN:  if (last)          state_d = S_DONE;
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_rdy  = (state_q == S_IDLE);
    out_vld = (state_q == S_DONE);
  end

  // One full-subtractor cell fed from the operand LSBs
  assign x    = sa_q[0];
  assign y    = sb_q[0];
  assign dbit = x ^ y ^ br_q;
  assign br_n = (~x & y) | (~(x ^ y) & br_q);

  always_comb begin
    sa_d  = sa_q;
    sb_d  = sb_q;
    d_d   = d_q;
    br_d  = br_q;
    bo_d  = bo_q;
    cnt_d = cnt_q;
`ifdef SR_SUB_OVF_EN
    amsb_d = amsb_q;
    bmsb_d = bmsb_q;
    ovf_d  = ovf_q;
`endif
    if (state_q == S_IDLE && acc) begin
      sa_d  = bus.a;
      sb_d  = bus.b;
      br_d  = 1'b0;
      cnt_d = '0;
`ifdef SR_SUB_OVF_EN
      amsb_d = bus.a[W-1];
      bmsb_d = bus.b[W-1];
`endif
    end else if (state_q == S_RUN) begin
      sa_d  = sa_q >> 1;
      sb_d  = sb_q >> 1;
      d_d   = {dbit, d_q[W-1:1]};
      br_d  = br_n;
      // counter wraps on the last bit so it never exceeds W-1
      cnt_d = last ? '0 : cnt_q + 1'b1;
      if (last) begin
        bo_d = br_n;
`ifdef SR_SUB_OVF_EN
        ovf_d = (amsb_q ^ bmsb_q) & (amsb_q ^ dbit);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa_q  <= '0;
      sb_q  <= '0;
      d_q   <= '0;
      br_q  <= 1'b0;
      bo_q  <= 1'b0;
      cnt_q <= '0;
`ifdef SR_SUB_OVF_EN
      amsb_q <= 1'b0;
      bmsb_q <= 1'b0;
      ovf_q  <= 1'b0;
`endif
    end else begin
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      d_q   <= d_d;
      br_q  <= br_d;
      bo_q  <= bo_d;
      cnt_q <= cnt_d;
`ifdef SR_SUB_OVF_EN
      amsb_q <= amsb_d;
      bmsb_q <= bmsb_d;
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.d         = d_q;
  assign bus.bo        = bo_q;
`ifdef SR_SUB_OVF_EN
  assign bus.ovf       = ovf_q;
`endif
endmodule
